// File: rtl/hazard_unit.sv
// hazard_unit: scoreboard-based hazard controller for the 5-stage core.
// Tracks instructions leaving ID through EX, MEM and WB (advanced on the
// falling clock edge, like the pipeline registers) and drives PC/IF-ID hold,
// ID/EX bubble, IF-ID flush and the EX operand forwarding selects.
//
// Build option: define HAZARD_FWD_EN to enable EX operand forwarding. Then
// only a load-use hazard stalls. Without it, the forwarding selects are tied
// to 00 and any RAW hazard against the EX or MEM slot stalls.
//
// Control priority each cycle: flush > stall > run.
module hazard_unit #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rs3,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_use3,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    output logic             pc_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_c,
    output logic [CNT_W-1:0] stall_count
);

    // Destination record carried by every scoreboard slot.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
    } dst_t;

    // A slot "writes r" when it holds a live register-writing instruction
    // targeting r. Register 0 gets no special treatment.
    function automatic logic writes(input dst_t s, input logic [REG_W-1:0] r);
        return s.valid & s.regwrite & (s.rd == r);
    endfunction

    dst_t             ex_dst_q, ex_dst_d;
    dst_t             mem_dst_q, mem_dst_d;
    // The load flag only matters while the load sits in EX (load-use check).
    logic             ex_load_q, ex_load_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic raw_ex;
    logic load_use;
    logic stall_cond;
    logic do_flush;
    logic do_stall;

`ifdef HAZARD_FWD_EN
    // Sources of the instruction in EX, needed to pick forwarding selects.
    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rs3;
        logic             use1;
        logic             use2;
        logic             use3;
    } src_t;

    src_t ex_src_q, ex_src_d;
    // WB slot is only observable through forwarding: the register file
    // writes in WB and reads in ID in the same cycle, so it never stalls ID.
    dst_t wb_dst_q, wb_dst_d;

    // MEM result is younger than WB, so it wins when both write the source.
    function automatic logic [1:0] fwd_sel(input logic use_i,
                                           input logic [REG_W-1:0] rs,
                                           input dst_t mem_s,
                                           input dst_t wb_s);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_i && writes(mem_s, rs)) begin
            sel = 2'b01;
        end else if (use_i && writes(wb_s, rs)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction
`else
    logic raw_mem;
`endif

    // Hazard detection for the instruction currently in ID.
    always_comb begin : hazard_detect
        raw_ex = (id_use1 & writes(ex_dst_q, id_rs1)) |
                 (id_use2 & writes(ex_dst_q, id_rs2)) |
                 (id_use3 & writes(ex_dst_q, id_rs3));
        load_use = ex_load_q & raw_ex;
`ifdef HAZARD_FWD_EN
        // Everything except a load result still in EX can be forwarded.
        stall_cond = load_use;
`else
        raw_mem = (id_use1 & writes(mem_dst_q, id_rs1)) |
                  (id_use2 & writes(mem_dst_q, id_rs2)) |
                  (id_use3 & writes(mem_dst_q, id_rs3));
        // load_use is a subset of raw_ex; named here for readability.
        stall_cond = load_use | raw_ex | raw_mem;
`endif
        do_flush = ex_branch_taken;
        do_stall = stall_cond & ~do_flush;
    end

    // Pipeline control: a taken branch squashes both ID and IF and
    // overrides any stall in the same cycle.
    always_comb begin : control_out
        ifid_flush  = do_flush;
        pc_hold     = do_stall;
        idex_bubble = do_flush | do_stall;
    end

    // Forwarding selects for the three EX operands.
    always_comb begin : forward_sel
`ifdef HAZARD_FWD_EN
        fwd_a = fwd_sel(ex_src_q.use1, ex_src_q.rs1, mem_dst_q, wb_dst_q);
        fwd_b = fwd_sel(ex_src_q.use2, ex_src_q.rs2, mem_dst_q, wb_dst_q);
        fwd_c = fwd_sel(ex_src_q.use3, ex_src_q.rs3, mem_dst_q, wb_dst_q);
`else
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        fwd_c = 2'b00;
`endif
    end

    // Next scoreboard contents and saturating stall counter.
    always_comb begin : next_state
        ex_dst_d  = '0;
        ex_load_d = 1'b0;
        if (!idex_bubble) begin
            ex_dst_d.valid    = 1'b1;
            ex_dst_d.rd       = id_rd;
            ex_dst_d.regwrite = id_regwrite;
            ex_load_d         = id_memread;
        end
        mem_dst_d = ex_dst_q;

        stall_count_d = stall_count_q;
        if (do_stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Scoreboard and counter advance with the pipeline registers.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ex_dst_q      <= '0;
            ex_load_q     <= 1'b0;
            mem_dst_q     <= '0;
            stall_count_q <= '0;
        end else begin
            ex_dst_q      <= ex_dst_d;
            ex_load_q     <= ex_load_d;
            mem_dst_q     <= mem_dst_d;
            stall_count_q <= stall_count_d;
        end
    end

`ifdef HAZARD_FWD_EN
    // Forwarding-only state: EX sources and the WB slot.
    always_comb begin : next_state_fwd
        ex_src_d = '0;
        if (!idex_bubble) begin
            ex_src_d.rs1  = id_rs1;
            ex_src_d.rs2  = id_rs2;
            ex_src_d.rs3  = id_rs3;
            ex_src_d.use1 = id_use1;
            ex_src_d.use2 = id_use2;
            ex_src_d.use3 = id_use3;
        end
        wb_dst_d = mem_dst_q;
    end

    // Forwarding-only registers, same edge and reset as the scoreboard.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ex_src_q <= '0;
            wb_dst_q <= '0;
        end else begin
            ex_src_q <= ex_src_d;
            wb_dst_q <= wb_dst_d;
        end
    end
`endif

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. Inputs change 1 time unit after the
// falling (active) edge; outputs are sampled mid-cycle. A second instance
// with CNT_W=2 shares the inputs to check stall-counter saturation.
// Follows HAZARD_FWD_EN the same way as the design.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [3:0] id_rs1, id_rs2, id_rs3, id_rd;
  logic       id_use1, id_use2, id_use3;
  logic       id_regwrite, id_memread, ex_branch_taken;
  logic       pc_hold, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b, fwd_c;
  logic [15:0] stall_count;
  logic       s_pc_hold, s_ifid_flush, s_idex_bubble;
  logic [1:0] s_fwd_a, s_fwd_b, s_fwd_c;
  logic [1:0] s_stall_count;

  int checks = 0;
  int failures = 0;

  hazard_unit #(.REG_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_use1(id_use1), .id_use2(id_use2), .id_use3(id_use3),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall_count(stall_count)
  );

  hazard_unit #(.REG_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_use1(id_use1), .id_use2(id_use2), .id_use3(id_use3),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(s_pc_hold), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_c(s_fwd_c),
    .stall_count(s_stall_count)
  );

  // clock / reset
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // ---- driver tasks ----
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rs2, input logic u2,
                       input logic [3:0] rs3, input logic u3,
                       input logic [3:0] rd, input logic rw,
                       input logic mr, input logic br);
    id_rs1 = rs1; id_use1 = u1;
    id_rs2 = rs2; id_use2 = u2;
    id_rs3 = rs3; id_use3 = u3;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
    ex_branch_taken = br;
  endtask

  task automatic nop();
    drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // producer: writes rd, optionally a load
  task automatic wr(input logic [3:0] rd, input logic mr);
    drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, rd, 1'b1, mr, 1'b0);
  endtask

  // consumer: reads register r on source slot idx (1..3), no write
  task automatic rd_src(input int idx, input logic [3:0] r, input logic br);
    drive(r, idx == 1, r, idx == 2, r, idx == 3, 4'd0, 1'b0, 1'b0, br);
  endtask

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic hold, input logic flush, input logic bub);
    #2;
    check({tag, ".pc_hold"}, 32'(pc_hold), 32'(hold));
    check({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(flush));
    check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    #2;
    check({tag, ".fwd_a"}, 32'(fwd_a), 32'(a));
    check({tag, ".fwd_b"}, 32'(fwd_b), 32'(b));
    check({tag, ".fwd_c"}, 32'(fwd_c), 32'(c));
  endtask

  // main counter exact; 2-bit instance saturates at 3
  task automatic chk_cnt(input string tag, input int e);
    check({tag, ".stall_count"}, 32'(stall_count), 32'(e));
    check({tag, ".sat_count"}, 32'(s_stall_count), (e > 3) ? 32'd3 : 32'(e));
  endtask

  initial begin
    rst = 1'b1;
    nop();
    tick();
    tick();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk_fwd("reset", 2'd0, 2'd0, 2'd0);
    chk_cnt("reset", 0);
    tick();
    rst = 1'b0;

`ifdef HAZARD_FWD_EN
    // ALU RAW on previous instruction: forwarded from MEM, no stall
    wr(4'd3, 1'b0); chk_ctl("raw_prod", 1'b0, 1'b0, 1'b0); tick();
    rd_src(1, 4'd3, 1'b0); chk_ctl("raw_nostall", 1'b0, 1'b0, 1'b0); tick();
    nop(); chk_fwd("raw_fwd_mem", 2'd1, 2'd0, 2'd0); tick();
    chk_cnt("raw_nostall", 0);

    // RAW two instructions back: forwarded from WB
    wr(4'd6, 1'b0); tick();
    nop(); tick();
    rd_src(1, 4'd6, 1'b0); chk_ctl("raw2_nostall", 1'b0, 1'b0, 1'b0); tick();
    nop(); chk_fwd("raw2_fwd_wb", 2'd2, 2'd0, 2'd0); tick();

    // MEM beats WB on the same register; unused source never forwards
    wr(4'd2, 1'b0); tick();
    wr(4'd2, 1'b0); tick();
    drive(4'd0, 1'b0, 4'd2, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    nop(); chk_fwd("prio_mem", 2'd0, 2'd0, 2'd1); tick();

    // load-use: one stall, then forward from WB
    wr(4'd5, 1'b1); chk_ctl("lu_prod", 1'b0, 1'b0, 1'b0); tick();
    rd_src(2, 4'd5, 1'b0); chk_ctl("lu_stall", 1'b1, 1'b0, 1'b1); tick();
    chk_cnt("lu_stall", 1);
    chk_ctl("lu_release", 1'b0, 1'b0, 1'b0); tick();
    nop(); chk_fwd("lu_fwd_wb", 2'd0, 2'd2, 2'd0); tick();
    chk_cnt("lu_after", 1);

    // branch in the cycle the load-use stall would assert
    wr(4'd5, 1'b1); tick();
    rd_src(2, 4'd5, 1'b1); chk_ctl("br_lu", 1'b0, 1'b1, 1'b1); tick();
    chk_cnt("br_lu", 1);
    nop(); chk_ctl("br_after", 1'b0, 1'b0, 1'b0); tick();

    // four more load-use stalls: 2-bit counter saturates
    for (int k = 0; k < 4; k++) begin
      wr(4'd5, 1'b1); tick();
      rd_src(2, 4'd5, 1'b0); chk_ctl($sformatf("sat_stall%0d", k), 1'b1, 1'b0, 1'b1); tick();
      chk_cnt($sformatf("sat%0d", k), 2 + k);
      tick();
    end

    // reset asserted mid-stall
    wr(4'd9, 1'b1); tick();
    rd_src(1, 4'd9, 1'b0); chk_ctl("rst_pre", 1'b1, 1'b0, 1'b1);
`else
    // ALU RAW on previous instruction: two stall cycles, no forwarding
    wr(4'd7, 1'b0); chk_ctl("raw_prod", 1'b0, 1'b0, 1'b0); tick();
    rd_src(1, 4'd7, 1'b0); chk_ctl("raw_stall_ex", 1'b1, 1'b0, 1'b1);
    chk_fwd("raw_stall_ex", 2'd0, 2'd0, 2'd0); tick();
    chk_cnt("raw_stall1", 1);
    chk_ctl("raw_stall_mem", 1'b1, 1'b0, 1'b1); tick();
    chk_cnt("raw_stall2", 2);
    chk_ctl("raw_release", 1'b0, 1'b0, 1'b0); tick();
    nop(); chk_fwd("raw_fwd_off", 2'd0, 2'd0, 2'd0); tick();
    chk_cnt("raw_after", 2);

    // RAW two instructions back: one stall cycle
    wr(4'd4, 1'b0); tick();
    nop(); tick();
    rd_src(2, 4'd4, 1'b0); chk_ctl("raw2_stall", 1'b1, 1'b0, 1'b1); tick();
    chk_cnt("raw2_stall", 3);
    chk_ctl("raw2_release", 1'b0, 1'b0, 1'b0); tick();

    // unused sources never stall; WB slot never stalls
    wr(4'd0, 1'b0); tick();
    nop(); chk_ctl("use_gate", 1'b0, 1'b0, 1'b0); tick();
    nop(); tick();
    rd_src(3, 4'd0, 1'b0); chk_ctl("wb_no_hazard", 1'b0, 1'b0, 1'b0); tick();

    // register 0 is an ordinary register; source 3 stalls like the others
    wr(4'd0, 1'b0); tick();
    rd_src(3, 4'd0, 1'b0); chk_ctl("r0_stall_ex", 1'b1, 1'b0, 1'b1); tick();
    chk_cnt("r0_stall1", 4);
    chk_ctl("r0_stall_mem", 1'b1, 1'b0, 1'b1); tick();
    chk_cnt("r0_stall2_sat", 5);
    chk_ctl("r0_release", 1'b0, 1'b0, 1'b0); tick();

    // a load behaves like any producer here: two stalls
    wr(4'd5, 1'b1); tick();
    rd_src(2, 4'd5, 1'b0); chk_ctl("ld_stall_ex", 1'b1, 1'b0, 1'b1); tick();
    chk_ctl("ld_stall_mem", 1'b1, 1'b0, 1'b1); tick();
    chk_cnt("ld_stall", 7);
    chk_ctl("ld_release", 1'b0, 1'b0, 1'b0); tick();

    // flush during a two-cycle stall ends it that cycle
    wr(4'd8, 1'b0); tick();
    rd_src(1, 4'd8, 1'b0); chk_ctl("br_stall", 1'b1, 1'b0, 1'b1); tick();
    chk_cnt("br_stall", 8);
    rd_src(1, 4'd8, 1'b1); chk_ctl("br_flush", 1'b0, 1'b1, 1'b1); tick();
    chk_cnt("br_flush", 8);
    nop(); chk_ctl("br_after", 1'b0, 1'b0, 1'b0); tick();

    // reset asserted mid-stall
    wr(4'd9, 1'b0); tick();
    rd_src(1, 4'd9, 1'b0); chk_ctl("rst_pre", 1'b1, 1'b0, 1'b1);
`endif

    // common tail: asynchronous reset clears everything immediately
    #1 rst = 1'b1;
    chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0);
    chk_cnt("rst_mid", 0);
    tick();
    rst = 1'b0;
    chk_ctl("rst_first_run", 1'b0, 1'b0, 1'b0); tick();
    chk_cnt("rst_first_run", 0);
`ifdef HAZARD_FWD_EN
    wr(4'd9, 1'b1); tick();
`else
    wr(4'd9, 1'b0); tick();
`endif
    rd_src(1, 4'd9, 1'b0); chk_ctl("post_rst_ex", 1'b1, 1'b0, 1'b1); tick();
    chk_cnt("post_rst", 1);
    nop(); tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage core. It tracks every instruction leaving ID into the ID/EX, EX/MEM and MEM/WB registers in an internal scoreboard, and drives the control that acts on those registers: PC/IF-ID hold, ID/EX bubble insertion, IF-ID flush and EX operand forwarding selects. It is the consumer and controller of the ID/EX register's contents, advancing in lock-step with the pipeline registers.

## Interface
Parameters:
- REG_W, 4, register-specifier width (16 architectural registers)
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock; state updates on the falling edge, same as all pipeline registers
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2, id_rs3  in  REG_W  source specifiers of the instruction in ID
- id_use1, id_use2, id_use3  in  1  source actually read
- id_rd  in  REG_W  destination of the instruction in ID
- id_regwrite  in  1  ID instruction writes id_rd
- id_memread  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- pc_hold  out  1  freeze PC and IF/ID
- ifid_flush  out  1  clear IF/ID
- idex_bubble  out  1  load ID/EX with all-zero control
- fwd_a, fwd_b, fwd_c  out  2  EX operand select: 00 ID/EX value, 01 EX/MEM result, 10 MEM/WB result
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard slots EX, MEM, WB; each holds {valid, rd, regwrite, memread}; EX additionally holds rs1..rs3 and use1..use3.
- Each falling edge: WB<=MEM, MEM<=EX, EX<=ID entry, or EX<=empty (valid=0) when idex_bubble=1.
- A slot "writes r" when valid & regwrite & rd==r. Register 0 is not special.
- Hazard for source i of ID: id_use_i=1 and a slot writes id_rs_i.
- load_use: hazard against EX slot with memread=1.
- Priority per cycle: flush > stall > run.
  - flush (ex_branch_taken=1): ifid_flush=1, idex_bubble=1, pc_hold=0. Stall is suppressed.
  - stall (condition in Configuration, no flush): pc_hold=1, idex_bubble=1, ifid_flush=0. stall_count increments, saturating at 2^CNT_W-1.
  - run: all three 0.
- Forwarding (EX stage, combinational from scoreboard): for EX source i with use_i=1:
  - MEM slot writes rs_i -> 01.
  - else WB slot writes rs_i -> 10.
  - else 00.
  - MEM has priority over WB.
- Register file writes in WB and reads in ID in the same cycle. The WB slot therefore never causes an ID hazard.

## Timing
- pc_hold, ifid_flush, idex_bubble and fwd_* are combinational from inputs and scoreboard, valid before the falling edge.
- Reset (asynchronous, immediate): all slots invalid, stall_count=0, so all outputs are 0.
- Load-use costs exactly 1 stall cycle with forwarding. The load then sits in MEM; on the following cycle the consumer is in EX and the load is in WB, so fwd=10.
- Taken branch costs 2 squashed instructions: the ID instruction is bubbled and the IF instruction is flushed, in the same cycle.
- Flush arriving during a multi-cycle stall ends the stall that cycle.
- rst asserted mid-stall clears the scoreboard. The first cycle after release is run.

## Configuration
- HAZARD_FWD_EN defined: forwarding active as above. Stall condition = load_use only.
- HAZARD_FWD_EN undefined: fwd_a/b/c are tied to 00. Stall condition = any ID hazard against the EX or MEM slot, load or not. An ALU RAW on the immediately preceding instruction therefore stalls 2 cycles, and on the instruction before that 1 cycle.

## Test plan
- Reset: hold rst=1 mid-stream, then release. Required: all outputs 0, stall_count=0; first ID entry enters EX on the next falling edge.
- ALU RAW, FWD_EN: issue add r3 (regwrite, rd=3), then sub using rs1=3. Required: no stall; consumer in EX sees fwd_a=01. With rs1 on the instruction two later: fwd_a=10.
- Load-use, FWD_EN: issue load rd=5, then use rs2=5. Required: exactly 1 cycle of pc_hold=1 and idex_bubble=1, stall_count=1, then fwd_b=10.
- No FWD_EN: issue add rd=7, then use rs1=7. Required: 2 stall cycles, fwd_a=00 throughout, stall_count=2.
- Branch during load-use stall: ex_branch_taken=1 in the cycle stall would assert. Required: ifid_flush=1, idex_bubble=1, pc_hold=0, stall_count unchanged.
- Saturation with CNT_W=2: force 5 consecutive stall cycles. Required: stall_count stops at 3.
